// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared mode encoding, counter width and speed-period helper for the CPU run controller
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } mode_t;
  localparam int CYCLE_COUNT_W = 16;
  // Cycles between enable ticks: 1 at speed 0, else base * 4^(k-1).
  function automatic logic [31:0] speed_period(input logic [31:0] base, input logic [31:0] k);
    return (k == 32'd0) ? 32'd1 : base << (2 * (k - 32'd1));
  endfunction
endpackage

// File: rtl/cpu_run_controller_edge.sv
// rising_edge_detector: one-cycle pulse in the cycle a debounced level first reads high
//   clk, rst : clock and synchronous active-high reset
//   in       : debounced level
//   pulse    : in high while the previous-cycle sample was low
module rising_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic prev;
  // History follows the level even during reset, so a button held across
  // reset deassertion is treated as already pressed and yields no edge.
  always_ff @(posedge clk)
    prev <= in;
  assign pulse = in && !prev && !rst;
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences CPU clock-enable with free-run speeds, single-step, pause and sticky halt
//   clk, rst                  : clock, synchronous active-high reset
//   btnRun, btnStep, btnSpeed : debounced button levels (rising edges act)
//   haltFlag                  : CPU halt indication
//   cpuEnable                 : CPU advances one cycle on each clk edge where high
//   mode                      : current mode_t state
//   speedIdx                  : current speed setting
//   cycleCount                : count of enabled cycles, wraps
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_BASE = 25000,
  parameter int unsigned NUM_SPEEDS    = 4,
  parameter bit          START_RUNNING = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btnRun,
  input  logic                          btnStep,
  input  logic                          btnSpeed,
  input  logic                          haltFlag,
  output logic                          cpuEnable,
  output logic [1:0]                    mode,
  output logic [$clog2(NUM_SPEEDS)-1:0] speedIdx,
  output logic [CYCLE_COUNT_W-1:0]      cycleCount
);
  localparam int SW = $clog2(NUM_SPEEDS);
  localparam mode_t RESET_MODE = START_RUNNING ? RUN : PAUSED;
  mode_t state, state_n;
  logic [31:0] presc;
  logic [SW-1:0] speed_n;
  logic run_edge, step_edge, speed_edge, tick;
  rising_edge_detector u_run   (.clk(clk), .rst(rst), .in(btnRun),   .pulse(run_edge));
  rising_edge_detector u_step  (.clk(clk), .rst(rst), .in(btnStep),  .pulse(step_edge));
  rising_edge_detector u_speed (.clk(clk), .rst(rst), .in(btnSpeed), .pulse(speed_edge));
  assign tick = presc == 32'd0;
  // The reset cycle itself must not advance the CPU, even mid-RUN or mid-STEP.
  assign cpuEnable = !rst && !haltFlag && ((state == RUN && tick) || state == STEP);
  assign mode = state;
  assign speed_n = (speedIdx == SW'(NUM_SPEEDS - 1)) ? '0 : speedIdx + 1'b1;
  always_comb begin
    state_n = state;
    case (state)
      PAUSED:  state_n = haltFlag ? HALTED : run_edge ? RUN : step_edge ? STEP : PAUSED;
      RUN:     state_n = haltFlag ? HALTED : run_edge ? PAUSED : RUN;
      STEP:    state_n = haltFlag ? HALTED : PAUSED;
      default: state_n = HALTED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RESET_MODE;
      speedIdx   <= '0;
      presc      <= '0;
      cycleCount <= '0;
    end else begin
      state      <= state_n;
      cycleCount <= cycleCount + CYCLE_COUNT_W'(cpuEnable);
      if (speed_edge)
        speedIdx <= speed_n;
      // Clearing the prescaler makes the first pulse land in the first cycle at the new setting.
      if (speed_edge || (state == PAUSED && state_n == RUN))
        presc <= '0;
      else if (state == RUN)
        presc <= tick ? speed_period(32'(PRESCALE_BASE), 32'(speedIdx)) - 32'd1 : presc - 32'd1;
    end
  end
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed checks of run/step/pause/halt, speed periods and counter wrap
module tb_cpu_run_controller;
  import cpu_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_a = 0, step_a = 0, speed_a = 0, halt_a = 0, en_a;
  logic run_b = 0, step_b = 0, speed_b = 0, halt_b = 0, en_b;
  logic [1:0] mode_a, mode_b, spd_a, spd_b;
  logic [15:0] cnt_a, cnt_b;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  cpu_run_controller #(.PRESCALE_BASE(4), .NUM_SPEEDS(4), .START_RUNNING(1'b1)) dut_a (
    .clk(clk), .rst(rst), .btnRun(run_a), .btnStep(step_a), .btnSpeed(speed_a),
    .haltFlag(halt_a), .cpuEnable(en_a), .mode(mode_a), .speedIdx(spd_a), .cycleCount(cnt_a)
  );
  cpu_run_controller #(.PRESCALE_BASE(4), .NUM_SPEEDS(4), .START_RUNNING(1'b0)) dut_b (
    .clk(clk), .rst(rst), .btnRun(run_b), .btnStep(step_b), .btnSpeed(speed_b),
    .haltFlag(halt_b), .cpuEnable(en_b), .mode(mode_b), .speedIdx(spd_b), .cycleCount(cnt_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int hits;
    go(2);
    chk("rst_mode_a", mode_a, RUN);
    chk("rst_en_a", en_a, 0);
    chk("rst_mode_b", mode_b, PAUSED);
    chk("rst_cnt_b", cnt_b, 0);
    rst = 0;
    #1;
    chk("idle_en_b", en_b, 0);
    for (int i = 0; i < 3; i++) begin
      step_b = 1;
      go(1);
      step_b = 0;
      #1;
      chk("step_mode_b", mode_b, STEP);
      chk("step_en_b", en_b, 1);
      go(1);
      chk("step_back_b", mode_b, PAUSED);
      chk("step_off_b", en_b, 0);
      go(2);
    end
    chk("step_cnt_b", cnt_b, 3);
    speed_b = 1; go(1); speed_b = 0; go(1); speed_b = 1; go(1); speed_b = 0;
    chk("spd2_b", spd_b, 2);
    run_b = 1;
    go(1);
    run_b = 0;
    #1;
    chk("run_mode_b", mode_b, RUN);
    for (int k = 0; k < 40; k++) begin
      chk("run16_en_b", en_b, (k % 16 == 0) ? 1 : 0);
      go(1);
    end
    run_b = 1;
    go(1);
    run_b = 0;
    chk("pause_mode_b", mode_b, PAUSED);
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      hits += int'(en_b);
      go(1);
    end
    chk("paused_quiet_b", hits, 0);
    chk("run16_cnt_b", cnt_b, 6);
    run_b = 1; step_b = 1;
    go(1);
    run_b = 0; step_b = 0;
    chk("run_over_step_b", mode_b, RUN);
    run_b = 1;
    rst = 1;
    go(2);
    chk("rst2_cnt_b", cnt_b, 0);
    rst = 0;
    go(1);
    chk("held_run_b", mode_b, PAUSED);
    go(1);
    chk("held_run2_b", mode_b, PAUSED);
    run_b = 0;
    halt_b = 1;
    go(1);
    halt_b = 0;
    chk("paused_halt_b", mode_b, HALTED);
    rst = 1;
    go(1);
    rst = 0;
    #1;
    hits = 0;
    for (int k = 0; k < 100; k++) begin
      hits += int'(en_a);
      go(1);
    end
    chk("free_hits_a", hits, 100);
    chk("free_cnt_a", cnt_a, 100);
    go(10);
    halt_a = 1;
    #1;
    chk("halt_en_a", en_a, 0);
    go(1);
    halt_a = 0;
    #1;
    chk("halt_mode_a", mode_a, HALTED);
    chk("halt_cnt_a", cnt_a, 110);
    run_a = 1; go(1); run_a = 0; step_a = 1; go(1); step_a = 0;
    #1;
    chk("halt_sticky_a", mode_a, HALTED);
    chk("halt_en2_a", en_a, 0);
    chk("halt_cnt2_a", cnt_a, 110);
    speed_a = 1; go(1); speed_a = 0;
    chk("halt_speed_a", spd_a, 1);
    rst = 1;
    go(1);
    rst = 0;
    #1;
    chk("resume_mode_a", mode_a, RUN);
    chk("resume_en_a", en_a, 1);
    chk("resume_spd_a", spd_a, 0);
    go(65535);
    chk("cnt_ffff_a", cnt_a, 16'hFFFF);
    go(1);
    chk("cnt_wrap_a", cnt_a, 0);
    for (int i = 1; i <= 4; i++) begin
      speed_a = 1; go(1); speed_a = 0; go(1);
      chk("spd_cycle_a", spd_a, i % 4);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
